// File: rtl/mbist_pkg.sv
// March C- sequence tables and shared types for the MBIST controller.
// Pure definitions; no logic, no latency, no flow control.
package mbist_pkg;

    localparam int NUM_ELEM = 6;
    localparam int ELEM_W   = 3;

    typedef logic [2:0] state_e;

    localparam state_e ST_IDLE  = 3'd0;
    localparam state_e ST_LOAD  = 3'd1;
    localparam state_e ST_OP0   = 3'd2;
    localparam state_e ST_OP1   = 3'd3;
    localparam state_e ST_DONE  = 3'd4;
    localparam state_e ST_ABORT = 3'd5;

    typedef struct packed {
        logic rd;   // 1 = read/compare, 0 = write
        logic bg;   // background bit replicated across the word
    } march_op_t;

    typedef struct packed {
        logic      up;
        logic      two_ops;
        march_op_t op0;
        march_op_t op1;
    } march_elem_t;

    localparam march_elem_t MARCH_CM [NUM_ELEM] = '{
        '{up: 1'b1, two_ops: 1'b0, op0: '{rd: 1'b0, bg: 1'b0}, op1: '{rd: 1'b0, bg: 1'b0}},
        '{up: 1'b1, two_ops: 1'b1, op0: '{rd: 1'b1, bg: 1'b0}, op1: '{rd: 1'b0, bg: 1'b1}},
        '{up: 1'b1, two_ops: 1'b1, op0: '{rd: 1'b1, bg: 1'b1}, op1: '{rd: 1'b0, bg: 1'b0}},
        '{up: 1'b0, two_ops: 1'b1, op0: '{rd: 1'b1, bg: 1'b0}, op1: '{rd: 1'b0, bg: 1'b1}},
        '{up: 1'b0, two_ops: 1'b1, op0: '{rd: 1'b1, bg: 1'b1}, op1: '{rd: 1'b0, bg: 1'b0}},
        '{up: 1'b1, two_ops: 1'b0, op0: '{rd: 1'b1, bg: 1'b0}, op1: '{rd: 1'b0, bg: 1'b0}}
    };

endpackage

// File: rtl/mbist_resp_cmp.sv
// Read-response checker: registers expectation on a read, compares next cycle (1-cycle latency).
// No backpressure; sticky fail with first-fail address/element capture, cleared by clr.
module mbist_resp_cmp
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ELEM_W-1:0] rd_elem,
    input  logic [DATA_W-1:0] rdata,
    output logic              miscmp,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ELEM_W-1:0] fail_elem
);

    logic              exp_vld;
    logic [DATA_W-1:0] exp_dat;
    logic [ADDR_W-1:0] exp_addr;
    logic [ELEM_W-1:0] exp_elem;

    assign miscmp = exp_vld && (rdata != exp_dat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_vld   <= 1'b0;
            exp_dat   <= '0;
            exp_addr  <= '0;
            exp_elem  <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            exp_vld <= rd_en;
            if (rd_en) begin
                exp_dat  <= rd_exp;
                exp_addr <= rd_addr;
                exp_elem <= rd_elem;
            end
            if (clr) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
            end else if (miscmp) begin
                fail <= 1'b1;
                // Only the first miscompare of a run is recorded.
                if (!fail) begin
                    fail_addr <= exp_addr;
                    fail_elem <= exp_elem;
                end
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer driving an external up/down address counter; run takes 10N+13 cycles to done.
// No backpressure; start ignored while busy. MBIST_STOP_ON_FAIL_EN aborts on the first miscompare.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] cnt_d_in,
    output logic              cnt_ld,
    output logic              cnt_u_d,
    output logic              cnt_cen,
    input  logic [ADDR_W-1:0] cnt_q,
    input  logic              cnt_cout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state, state_nxt;
    logic [ELEM_W-1:0] elem, elem_nxt;
    march_elem_t       cur;
    march_op_t         op;
    logic              op_act;
    logic              miscmp;
    logic              clr;

    assign cur      = MARCH_CM[elem];
    assign mem_addr = cnt_q;
    assign mem_re   = op_act && op.rd;
    assign mem_we   = op_act && !op.rd;
    assign mem_wdata = mem_we ? {DATA_W{op.bg}} : '0;
    assign busy     = (state == ST_LOAD) || (state == ST_OP0) ||
                      (state == ST_OP1)  || (state == ST_ABORT);
    assign clr      = (state == ST_DONE) && start;

    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        cnt_ld    = 1'b0;
        cnt_cen   = 1'b0;
        cnt_u_d   = 1'b1;
        cnt_d_in  = '0;
        op_act    = 1'b0;
        op        = cur.op0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    elem_nxt  = '0;
                end
            end
            ST_LOAD: begin
                cnt_ld    = 1'b1;
                cnt_cen   = 1'b1;
                cnt_u_d   = cur.up;
                cnt_d_in  = cur.up ? '0 : '1;
                state_nxt = ST_OP0;
            end
            ST_OP0: begin
                cnt_u_d = cur.up;
                // A wrapped counter ends the element; this cycle is the last read's compare slot.
                if (cnt_cout) begin
                    if (elem == ELEM_W'(NUM_ELEM - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        elem_nxt  = elem + 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end else begin
                    op_act = 1'b1;
                    op     = cur.op0;
                    if (cur.two_ops) begin
                        state_nxt = ST_OP1;
                    end else begin
                        cnt_cen = 1'b1;
                    end
                end
            end
            ST_OP1: begin
                cnt_u_d   = cur.up;
                op_act    = 1'b1;
                op        = cur.op1;
                cnt_cen   = 1'b1;
                state_nxt = ST_OP0;
            end
`ifdef MBIST_STOP_ON_FAIL_EN
            ST_ABORT: begin
                state_nxt = ST_DONE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
`ifdef MBIST_STOP_ON_FAIL_EN
        if (miscmp && ((state == ST_OP0) || (state == ST_OP1))) begin
            state_nxt = ST_ABORT;
        end
`endif
    end

`ifndef MBIST_STOP_ON_FAIL_EN
    logic miscmp_unused;
    assign miscmp_unused = miscmp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            elem  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            elem  <= elem_nxt;
            done  <= (state == ST_DONE) && !start;
        end
    end

    mbist_resp_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_resp_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .rd_en     (mem_re),
        .rd_exp    ({DATA_W{op.bg}}),
        .rd_addr   (cnt_q),
        .rd_elem   (elem),
        .rdata     (mem_rdata),
        .miscmp    (miscmp),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl with a behavioural address counter and memory (ADDR_W=4).
`timescale 1ns/1ps
module tb_mbist_march_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int N      = 16;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [ADDR_W-1:0] cnt_d_in;
    logic              cnt_ld, cnt_u_d, cnt_cen;
    logic [ADDR_W-1:0] cnt_q;
    logic              cnt_cout;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] mem [N];
    logic              fault_en = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .cnt_d_in  (cnt_d_in),
        .cnt_ld    (cnt_ld),
        .cnt_u_d   (cnt_u_d),
        .cnt_cen   (cnt_cen),
        .cnt_q     (cnt_q),
        .cnt_cout  (cnt_cout),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Loadable up/down counter with a registered wrap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cnt_cout <= 1'b0;
        end else if (cnt_cen) begin
            if (cnt_ld) begin
                cnt_q    <= cnt_d_in;
                cnt_cout <= 1'b0;
            end else if (cnt_u_d) begin
                cnt_q    <= cnt_q + 1'b1;
                cnt_cout <= (cnt_q == '1);
            end else begin
                cnt_q    <= cnt_q - 1'b1;
                cnt_cout <= (cnt_q == '0);
            end
        end
    end

    // Memory with optional bit0 stuck-at-1 on address 3.
    initial for (int i = 0; i < N; i++) mem[i] = 8'hA5;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr] | ((fault_en && mem_addr == 4'd3) ? 8'h01 : 8'h00);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int lat;
        bit from_fail;
        int busy_cyc;
        int fail;
        int faddr;
        int felem;
        int nwe;
        int nre;
        int post;
    } run_t;

    run_t exp_q[$];
    int   addr_q[$];
    int   ld_q[$];

    int   cyc = 0, b0 = 0, f0 = -1, nbusy = 0, nwe = 0, nre = 0, npost = 0, ld_cnt = 0;
    logic busy_p = 1'b0, done_p = 1'b0;
    run_t r;
    int   e;

    // Monitor: tracks each run and checks it against the queued expectation when done rises.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy_p = 1'b0;
            done_p = 1'b0;
        end else begin
            if (busy && !busy_p) begin
                b0 = cyc; f0 = -1; nbusy = 0; nwe = 0; nre = 0; npost = 0; ld_cnt = 0;
            end
            if (busy) nbusy++;
            if (mem_we) nwe++;
            if (mem_re) nre++;
            if (fail && f0 < 0) f0 = cyc;
            if (fail && (mem_we || mem_re)) npost++;
            if (cnt_ld) begin
                ld_cnt++;
                if (ld_cnt == 4 && ld_q.size() > 0) begin
                    e = ld_q.pop_front();
                    check("elem3_load_u_d", 32'(cnt_u_d), 32'd0);
                    check("elem3_load_d_in", 32'(cnt_d_in), 32'(e));
                end
            end
            if (ld_cnt == 4 && mem_re && addr_q.size() > 0) begin
                e = addr_q.pop_front();
                check("elem3_read_addr", 32'(mem_addr), 32'(e));
            end
            if (done && !done_p) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: done rose at cycle %0d, expected no run", cyc);
                end else begin
                    r = exp_q.pop_front();
                    check("done_latency", 32'(r.from_fail ? cyc - f0 : cyc - b0), 32'(r.lat));
                    check("busy_cycles", 32'(nbusy), 32'(r.busy_cyc));
                    check("fail_flag", 32'(fail), 32'(r.fail));
                    check("fail_addr", 32'(fail_addr), 32'(r.faddr));
                    check("fail_elem", 32'(fail_elem), 32'(r.felem));
                    check("write_count", 32'(nwe), 32'(r.nwe));
                    check("read_count", 32'(nre), 32'(r.nre));
                    check("strobes_after_fail", 32'(npost), 32'(r.post));
                end
            end
            busy_p = busy;
            done_p = done;
        end
    end

    task automatic push_run(input int lat, input bit from_fail, input int bc, input int fl,
                            input int fa, input int fe, input int we, input int re, input int post);
        run_t x;
        x.lat = lat; x.from_fail = from_fail; x.busy_cyc = bc; x.fail = fl;
        x.faddr = fa; x.felem = fe; x.nwe = we; x.nre = re; x.post = post;
        exp_q.push_back(x);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: done still low, expected high within 400 cycles", name);
        end
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_flags"}, 32'({busy, done, fail, cnt_ld, cnt_cen, mem_we, mem_re, cnt_u_d}),
              32'b0000_0001);
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
        check({tag, "_fail_elem"}, 32'(fail_elem), 32'd0);
        check({tag, "_cnt_d_in"}, 32'(cnt_d_in), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Fault-free run plus element 3 (down) address ordering.
        ld_q.push_back(15);
        for (int a = 15; a >= 0; a--) addr_q.push_back(a);
        push_run(10*N + 13, 1'b0, 10*N + 12, 0, 0, 0, 5*N, 5*N, 0);
        pulse_start();
        wait_done("fault_free");

        // Bit0 of address 3 stuck at 1; first miscompare is r0 of element 1.
        fault_en = 1'b1;
`ifdef MBIST_STOP_ON_FAIL_EN
        push_run(2, 1'b1, 28, 1, 3, 1, 20, 4, 0);
`else
        push_run(10*N + 13, 1'b0, 10*N + 12, 1, 3, 1, 5*N, 5*N, 136);
`endif
        pulse_start();
        wait_done("stuck_bit");

        // Restart from DONE with start held high for most of the run.
        fault_en = 1'b0;
        push_run(10*N + 13, 1'b0, 10*N + 12, 0, 0, 0, 5*N, 5*N, 0);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_fail_cleared", 32'(fail), 32'd0);
        check("restart_fail_addr_cleared", 32'(fail_addr), 32'd0);
        check("restart_done_cleared", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        repeat (100) @(posedge clk);
        #2 start = 1'b0;
        wait_done("held_start");

        // Reset in the middle of a run, then a clean run.
        pulse_start();
        repeat (50) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("midrun_reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        push_run(10*N + 13, 1'b0, 10*N + 12, 0, 0, 0, 5*N, 5*N, 0);
        pulse_start();
        wait_done("post_reset");

        check("runs_outstanding", 32'(exp_q.size()), 32'd0);
        check("elem3_reads_outstanding", 32'(addr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
